// File: rtl/udp_axis_pkt_gen_if.sv
// AXI-Stream bundle carrying the generator's 512-bit output stream.
interface udp_axis_pkt_gen_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/udp_axis_pkt_gen.sv
// Back-to-back AXI-Stream packet generator with deterministic payload and
// cycle/beat/packet counters for on-board throughput measurement.
module udp_axis_pkt_gen #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] pkt_size,
  input  logic [CNT_WIDTH-1:0] pkt_num,
  udp_axis_pkt_gen_if.master   m_axis,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  localparam int LANES = DATA_WIDTH / 32;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_WIDTH-1:0]  r_pkt_num;
  logic [CNT_WIDTH-1:0]  r_beats;
  logic [KEEP_WIDTH-1:0] r_last_keep;
  logic [CNT_WIDTH-1:0]  r_beat_idx;
  logic [CNT_WIDTH-1:0]  r_cycle_count;
  logic [CNT_WIDTH-1:0]  r_beat_count;
  logic [CNT_WIDTH-1:0]  r_pkt_count;
  logic                  r_tvalid;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic                  r_tlast;

  logic                  w_hs;
  logic                  w_final;
  logic [CNT_WIDTH-1:0]  w_cfg_beats;
  logic [KEEP_WIDTH-1:0] w_cfg_keep;
  logic [CNT_WIDTH-1:0]  w_next_idx;
  logic                  w_next_last;
  logic [CNT_WIDTH-1:0]  w_next_bc;

  // Lane k of a beat carries (beat_count << 4) | k.
  function automatic logic [DATA_WIDTH-1:0] f_payload(input logic [CNT_WIDTH-1:0] bc);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      d[k*32 +: 32] = 32'(bc << 4) | 32'(k);
    end
    return d;
  endfunction

  // Config decode at latch time and next-beat precomputation, so every
  // stream output can be loaded straight into its register on a handshake.
  always_comb begin
    w_hs        = r_tvalid & m_axis.tready;
    w_final     = r_tlast && ((r_pkt_count + CNT_WIDTH'(1)) == r_pkt_num);
    w_cfg_beats = CNT_WIDTH'(pkt_size[CNT_WIDTH-1:6]) + CNT_WIDTH'(|pkt_size[5:0]);
    w_cfg_keep  = '1;
    if (pkt_size[5:0] != 6'd0) begin
      w_cfg_keep = (KEEP_WIDTH'(1) << pkt_size[5:0]) - KEEP_WIDTH'(1);
    end
    w_next_idx  = r_tlast ? '0 : r_beat_idx + CNT_WIDTH'(1);
    w_next_last = (w_next_idx == (r_beats - CNT_WIDTH'(1)));
    w_next_bc   = r_beat_count + CNT_WIDTH'(1);
  end

  // Control FSM with registered stream outputs and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pkt_num     <= '0;
      r_beats       <= '0;
      r_last_keep   <= '0;
      r_beat_idx    <= '0;
      r_cycle_count <= '0;
      r_beat_count  <= '0;
      r_pkt_count   <= '0;
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_tkeep       <= '0;
      r_tlast       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (pkt_size != '0) && (pkt_num != '0)) begin
            r_state       <= S_SEND;
            r_busy        <= 1'b1;
            r_pkt_num     <= pkt_num;
            r_beats       <= w_cfg_beats;
            r_last_keep   <= w_cfg_keep;
            r_beat_idx    <= '0;
            r_cycle_count <= '0;
            r_beat_count  <= '0;
            r_pkt_count   <= '0;
            r_tvalid      <= 1'b1;
            r_tdata       <= f_payload('0);
            r_tlast       <= (w_cfg_beats == CNT_WIDTH'(1));
            r_tkeep       <= (w_cfg_beats == CNT_WIDTH'(1)) ? w_cfg_keep : '1;
          end
        end
        S_SEND: begin
          r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
          if (w_hs) begin
            r_beat_count <= w_next_bc;
            if (r_tlast) begin
              r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
            if (w_final) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
            end else begin
              r_beat_idx <= w_next_idx;
              r_tdata    <= f_payload(w_next_bc);
              r_tlast    <= w_next_last;
              r_tkeep    <= w_next_last ? r_last_keep : '1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tkeep  = r_tkeep;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = 1'b0;
  assign busy          = r_busy;
  assign done          = r_done;
  assign cycle_count   = r_cycle_count;
  assign beat_count    = r_beat_count;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_udp_axis_pkt_gen.sv
// Self-checking bench for udp_axis_pkt_gen: directed and randomized runs
// compared beat by beat against an arithmetic packet model.
module tb_udp_axis_pkt_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [31:0] pkt_size;
  logic [31:0] pkt_num;
  logic        busy;
  logic        done;
  logic [31:0] cycle_count;
  logic [31:0] beat_count;
  logic [31:0] pkt_count;

  udp_axis_pkt_gen_if #(.DATA_WIDTH(512), .KEEP_WIDTH(64)) m_axis ();

  udp_axis_pkt_gen #(.DATA_WIDTH(512), .KEEP_WIDTH(64), .CNT_WIDTH(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .pkt_size    (pkt_size),
    .pkt_num     (pkt_num),
    .m_axis      (m_axis),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count),
    .beat_count  (beat_count),
    .pkt_count   (pkt_count)
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned last_cyc = 0;
  int unsigned last_beat = 0;
  int unsigned last_pkt = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Payload of the g-th beat of a run.
  function automatic logic [511:0] model_data(input int unsigned g);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = (g * 16) + k;
    return d;
  endfunction

  // Byte-enable of a beat: full unless it is the last beat of a packet.
  function automatic logic [63:0] model_keep(input int unsigned size, input bit last);
    logic [63:0] all;
    int unsigned rem;
    all = '1;
    rem = size % 64;
    if (!last || rem == 0) return all;
    return all >> (64 - rem);
  endfunction

  // mode 0: tready always 1; mode 1: pattern 1,0,0; mode 2: random.
  // abort_at != 0 asserts RST after that many beats have been accepted.
  task automatic run(input int unsigned size, input int unsigned num, input int unsigned mode,
                     input bit poke_start, input int unsigned abort_at);
    int unsigned nb, total, g, cyc;
    bit r, finished;
    nb = (size + 63) / 64;
    total = nb * num;
    g = 0; cyc = 0; finished = 0;
    @(negedge CLK);
    start = 1'b1; pkt_size = size; pkt_num = num; m_axis.tready = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0; pkt_size = $urandom; pkt_num = $urandom;
    for (int it = 0; it < 4000; it++) begin
      @(negedge CLK);
      if (abort_at != 0 && g == abort_at) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_tvalid", 512'(m_axis.tvalid), 512'(0));
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_done", 512'(done), 512'(0));
        chk("abort_cycle", 512'(cycle_count), 512'(0));
        chk("abort_beat", 512'(beat_count), 512'(0));
        chk("abort_pkt", 512'(pkt_count), 512'(0));
        last_cyc = 0; last_beat = 0; last_pkt = 0;
        finished = 1;
        break;
      end
      if (g == total) begin
        chk("done_pulse", 512'(done), 512'(1));
        chk("done_busy", 512'(busy), 512'(0));
        chk("done_tvalid", 512'(m_axis.tvalid), 512'(0));
        chk("final_cycle", 512'(cycle_count), 512'(cyc));
        chk("final_beat", 512'(beat_count), 512'(total));
        chk("final_pkt", 512'(pkt_count), 512'(num));
        @(negedge CLK);
        chk("post_done", 512'(done), 512'(0));
        chk("post_busy", 512'(busy), 512'(0));
        chk("hold_cycle", 512'(cycle_count), 512'(cyc));
        chk("hold_beat", 512'(beat_count), 512'(total));
        last_cyc = cyc; last_beat = total; last_pkt = num;
        finished = 1;
        break;
      end
      chk("busy", 512'(busy), 512'(1));
      chk("done_low", 512'(done), 512'(0));
      chk("tvalid", 512'(m_axis.tvalid), 512'(1));
      chk("tuser", 512'(m_axis.tuser), 512'(0));
      chk("tdata", m_axis.tdata, model_data(g));
      chk("tlast", 512'(m_axis.tlast), 512'((g % nb) == nb - 1));
      chk("tkeep", 512'(m_axis.tkeep), 512'(model_keep(size, (g % nb) == nb - 1)));
      chk("cycle_count", 512'(cycle_count), 512'(cyc));
      chk("beat_count", 512'(beat_count), 512'(g));
      chk("pkt_count", 512'(pkt_count), 512'(g / nb));
      case (mode)
        0: r = 1'b1;
        1: r = (cyc % 3) == 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      m_axis.tready = r;
      start = poke_start && (cyc == 1);
      cyc++;
      if (r) g++;
    end
    start = 1'b0;
    m_axis.tready = 1'b0;
    if (!finished) chk("run_timeout", 512'(0), 512'(1));
  endtask

  // A start that must be ignored: nothing starts and counters hold.
  task automatic ignored_start(input int unsigned size, input int unsigned num);
    @(negedge CLK);
    start = 1'b1; pkt_size = size; pkt_num = num;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    chk("ign_busy", 512'(busy), 512'(0));
    chk("ign_tvalid", 512'(m_axis.tvalid), 512'(0));
    chk("ign_cycle", 512'(cycle_count), 512'(last_cyc));
    chk("ign_beat", 512'(beat_count), 512'(last_beat));
    chk("ign_pkt", 512'(pkt_count), 512'(last_pkt));
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; pkt_size = '0; pkt_num = '0; m_axis.tready = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tvalid", 512'(m_axis.tvalid), 512'(0));
    chk("rst_tlast", 512'(m_axis.tlast), 512'(0));
    chk("rst_tdata", m_axis.tdata, 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_cycle", 512'(cycle_count), 512'(0));
    RST = 1'b0;

    run(128, 4, 0, 0, 0);
    run(100, 2, 0, 0, 0);
    run(64, 3, 1, 0, 0);
    ignored_start(0, 5);
    ignored_start(64, 0);
    run(200, 3, 2, 1, 0);
    run(256, 2, 0, 0, 2);
    run(256, 2, 0, 0, 0);
    run(65, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(1, 300), $urandom_range(1, 4), 2, 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
